mod_reduct_solinas3: RTL and testbench
======================================

// Module: mod_reduct_solinas3
// PURPOSE
// - Pipelined modular reduction z = a mod MOD, where MOD = 2**MOD_W - 2**P0 - 2**P1 + 1 is a solinas3 prime.
// - Sits directly downstream of the solinas3 constant multipliers: consumes their 2*MOD_W-bit product and returns a canonical residue.
// - Fully pipelined: accepts one input per cycle, no backpressure.
// PARAMETERS
// - MOD_W     64                                     modulus width; input is 2*MOD_W bits
// - MOD       2**64-2**42-2**21+1                    solinas3 modulus; P0>P1 are derived from it
// - IN_PIPE   1                                      1: register the input (+1 latency); 0: combinational input
// - SIDE_W    0                                      side-data width; 0 = unused
// - RST_SIDE  0                                      [0]=1: side regs reset to 0; [1]=1: side regs reset to all-ones
// PORTS
// - clk        in   1            clock
// - a_rst      in   1            reset; asynchronous, active-high
// - a          in   2*MOD_W      value to reduce; any value in [0, 2**(2*MOD_W)-1]
// - in_avail   in   1            a/in_side valid this cycle
// - in_side    in   SIDE_W       side data travelling with a
// - z          out  MOD_W        a mod MOD, always in [0, MOD-1]
// - out_avail  out  1            z/out_side valid this cycle
// - out_side   out  SIDE_W       in_side delayed by LAT
// BEHAVIOUR
// - Elaboration: derive P0, P1 from MOD.
//   - $fatal if MOD != 2**MOD_W-2**P0-2**P1+1.
//   - $fatal if P0 > MOD_W-3 (folding would not converge).
// - Fold identity: 2**MOD_W == 2**P0 + 2**P1 - 1 (mod MOD).
//   - Each fold stage splits x (width Wi) into hi = x[Wi-1:MOD_W] and lo.
//   - It registers x' = (hi<<P0) + (hi<<P1) + lo - hi. The result is always >= 0.
// - Fold widths: W0 = 2*MOD_W; W(i+1) = max(MOD_W, Wi-MOD_W+P0+1) + 1.
//   - Stop when Wi <= MOD_W+2; NB_FOLD = number of folds performed.
//   - Defaults give widths 128 -> 108 -> 88 -> 68 -> 65, so NB_FOLD = 4.
// - Correction stage: x < 2**(MOD_W+2) < 5*MOD.
//   - Compare x against k*MOD for k=1..4 in parallel.
//   - Subtract the largest k*MOD <= x; one register stage.
// - Latency: LAT = IN_PIPE + NB_FOLD + 1 (+1 if the optional feature is enabled). Defaults: 6 (7).
// - Throughput: 1 per cycle.
//   - out_avail is in_avail delayed exactly LAT cycles; bubbles are preserved.
//   - Side data follows the same delay.
// - Data registers update every cycle regardless of avail. z is don't-care when out_avail=0.
// - Reset (asserted): immediate, asynchronous.
//   - All avail regs -> 0, so out_avail = 0.
//   - Side regs -> per RST_SIDE, otherwise 0.
//   - All data regs -> 0, so z = 0.
// - Reset mid-stream: every in-flight item is dropped; no out_avail pulse for items accepted before reset.
//   - First output after deassertion is the first in_avail sampled after deassertion, LAT cycles later.
// - Boundaries:
//   - a=0 -> 0; a=MOD -> 0; a=k*MOD -> 0.
//   - a = 2**(2*MOD_W)-1 must not overflow any fold stage.
//   - x exactly equal to k*MOD selects k (result 0).
// CONFIGURATION
// - Macro MOD_REDUCT_SOLINAS3_OUT_REG_EN:
//   - Defined: extra output register on z/out_avail/out_side; LAT+1. Reset values are unchanged.
//   - Undefined: z is driven directly by the correction-stage register.
// TESTING
// - (Defaults; LAT=6.) Reset, then a=0, in_avail=1 -> z=0, out_avail=1 exactly 6 cycles later; out_avail=0 in every other cycle.
// - a=0xFFFFFBFFFFE00001 (MOD) -> z=0.
//   - a=MOD-1 -> z=0xFFFFFBFFFFE00000.
//   - a=2**64 -> z=0x00000400001FFFFF.
// - a=2**128-1, a=(MOD-1)**2, plus 100k random a -> z equals the golden-model a mod MOD; no X on z.
// - Stream with in_avail pattern 1,1,0,1,0,0,1 and side=index (SIDE_W=8) -> identical avail pattern and side values 6 cycles later.
// - Assert a_rst with 3 items in flight -> out_avail=0 and z=0 immediately; the dropped items never appear; a new item after deassertion emerges LAT cycles later.
// - Rerun the directed and random tests with IN_PIPE=0 (LAT=5) and with MOD_REDUCT_SOLINAS3_OUT_REG_EN defined (LAT=7).

Source files
------------

// File: rtl/mod_reduct_solinas3.sv
// Pipelined z = a mod MOD for a solinas3 prime MOD = 2**MOD_W - 2**P0 - 2**P1 + 1.
// Define MOD_REDUCT_SOLINAS3_OUT_REG_EN to add an output register on z/out_avail/out_side (+1 latency).
module mod_reduct_solinas3 #(
    parameter int               MOD_W    = 64,
    parameter logic [MOD_W-1:0] MOD      = 64'hFFFF_FBFF_FFE0_0001,
    parameter int               IN_PIPE  = 1,
    parameter int               SIDE_W   = 0,
    parameter logic [1:0]       RST_SIDE = 2'b00
) (
    input  logic                                 clk,
    input  logic                                 a_rst,
    input  logic [2*MOD_W-1:0]                   a,
    input  logic                                 in_avail,
    input  logic [(SIDE_W > 0 ? SIDE_W : 1)-1:0] in_side,
    output logic [MOD_W-1:0]                     z,
    output logic                                 out_avail,
    output logic [(SIDE_W > 0 ? SIDE_W : 1)-1:0] out_side
);

    localparam int SW = (SIDE_W > 0) ? SIDE_W : 1;

    // 2**MOD_W - MOD + 1 must have exactly two set bits: P0 (upper) and P1 (lower).
    function automatic logic [MOD_W:0] mod_gap();
        return {1'b1, {MOD_W{1'b0}}} - {1'b0, MOD} + {{MOD_W{1'b0}}, 1'b1};
    endfunction

    function automatic int top_bit(input int rank);
        logic [MOD_W:0] d;
        int p0;
        int p1;
        d  = mod_gap();
        p0 = -1;
        p1 = -1;
        for (int b = 0; b <= MOD_W; b++) begin
            if (d[b]) begin
                p1 = p0;
                p0 = b;
            end
        end
        return (rank == 0) ? p0 : p1;
    endfunction

    localparam int P0_RAW = top_bit(0);
    localparam int P1_RAW = top_bit(1);
    localparam int P0     = (P0_RAW < 0) ? 0 : P0_RAW;
    localparam int P1     = (P1_RAW < 0) ? 0 : P1_RAW;

    function automatic bit mod_ok();
        logic [MOD_W:0] chk;
        if (P1_RAW < 0) return 1'b0;
        chk     = '0;
        chk[P0] = 1'b1;
        chk[P1] = 1'b1;
        return chk == mod_gap();
    endfunction

    function automatic int fold_w(input int n);
        int w;
        w = 2 * MOD_W;
        for (int i = 0; i < n; i++) begin
            w = ((MOD_W > w - MOD_W + P0 + 1) ? MOD_W : (w - MOD_W + P0 + 1)) + 1;
        end
        return w;
    endfunction

    function automatic int calc_nb_fold();
        int n;
        n = 0;
        for (int i = 0; i < 2 * MOD_W; i++) begin
            if (fold_w(n) > MOD_W + 2) n++;
        end
        return n;
    endfunction

`ifdef MOD_REDUCT_SOLINAS3_OUT_REG_EN
    localparam int OUT_REG = 1;
`else
    localparam int OUT_REG = 0;
`endif

    localparam bit MOD_OK  = mod_ok();
    localparam int NB_FOLD = calc_nb_fold();
    localparam int LAT     = ((IN_PIPE != 0) ? 1 : 0) + NB_FOLD + 1 + OUT_REG;
    localparam int CW      = MOD_W + 3;

    if (!MOD_OK) begin : g_bad_mod
        $fatal(1, "mod_reduct_solinas3: MOD is not 2**MOD_W - 2**P0 - 2**P1 + 1");
    end
    if (P0 > MOD_W - 3) begin : g_bad_p0
        $fatal(1, "mod_reduct_solinas3: P0 too large, folding would not converge");
    end

    logic [2*MOD_W-1:0] fold_in;

    if (IN_PIPE != 0) begin : g_in_reg
        logic [2*MOD_W-1:0] a_d, a_q;
        always_comb a_d = a;
        always_ff @(posedge clk or posedge a_rst) begin
            if (a_rst) a_q <= '0;
            else       a_q <= a_d;
        end
        assign fold_in = a_q;
    end else begin : g_in_comb
        assign fold_in = a;
    end

    // Each stage replaces hi*2**MOD_W by hi*(2**P0 + 2**P1 - 1); the result never goes negative.
    for (genvar i = 0; i < NB_FOLD; i++) begin : g_fold
        localparam int WI = fold_w(i);
        localparam int WO = fold_w(i + 1);
        logic [WI-1:0] x_in;
        logic [WO-1:0] hi_w, lo_w, x_d, x_q;
        if (i == 0) begin : g_src
            assign x_in = fold_in;
        end else begin : g_src
            assign x_in = g_fold[i-1].x_q;
        end
        always_comb begin
            hi_w = WO'(x_in[WI-1:MOD_W]);
            lo_w = WO'(x_in[MOD_W-1:0]);
            x_d  = (hi_w << P0) + (hi_w << P1) + lo_w - hi_w;
        end
        always_ff @(posedge clk or posedge a_rst) begin
            if (a_rst) x_q <= '0;
            else       x_q <= x_d;
        end
    end

    logic [CW-1:0]    corr_x, corr_sub;
    logic [MOD_W-1:0] corr_d, corr_q;

    // Folded value is below 4*2**MOD_W < 5*MOD; subtract the largest k*MOD not above it.
    always_comb begin
        corr_x   = CW'(g_fold[NB_FOLD-1].x_q);
        corr_sub = '0;
        for (int k = 1; k <= 4; k++) begin
            if (corr_x >= CW'(k) * CW'(MOD)) corr_sub = CW'(k) * CW'(MOD);
        end
        corr_d = MOD_W'(corr_x - corr_sub);
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) corr_q <= '0;
        else       corr_q <= corr_d;
    end

    localparam logic [SW-1:0] SIDE_RST = (RST_SIDE == 2'b10) ? {SW{1'b1}} : {SW{1'b0}};

    logic [LAT-1:0] avail_d, avail_q;
    logic [SW-1:0]  side_d [LAT];
    logic [SW-1:0]  side_q [LAT];

    always_comb begin
        avail_d   = {avail_q[LAT-2:0], in_avail};
        side_d[0] = in_side;
        for (int i = 1; i < LAT; i++) side_d[i] = side_q[i-1];
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            avail_q <= '0;
            for (int i = 0; i < LAT; i++) side_q[i] <= SIDE_RST;
        end else begin
            avail_q <= avail_d;
            side_q  <= side_d;
        end
    end

`ifdef MOD_REDUCT_SOLINAS3_OUT_REG_EN
    logic [MOD_W-1:0] z_d, z_q;
    always_comb z_d = corr_q;
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) z_q <= '0;
        else       z_q <= z_d;
    end
    assign z = z_q;
`else
    assign z = corr_q;
`endif

    assign out_avail = avail_q[LAT-1];
    assign out_side  = side_q[LAT-1];

endmodule

// File: tb/tb_mod_reduct_solinas3.sv
// Directed and random checks of mod_reduct_solinas3 with IN_PIPE=1 and IN_PIPE=0 instances side by side.
module tb_mod_reduct_solinas3;

    localparam logic [63:0] MOD = 64'hFFFF_FBFF_FFE0_0001;
`ifdef MOD_REDUCT_SOLINAS3_OUT_REG_EN
    localparam int LAT_P  = 7;
    localparam int LAT_NP = 6;
`else
    localparam int LAT_P  = 6;
    localparam int LAT_NP = 5;
`endif
    localparam int NV = 1024;

    logic         clk = 1'b0;
    logic         a_rst;
    logic [127:0] a;
    logic         in_avail;
    logic [7:0]   in_side;
    logic [63:0]  z_p, z_np;
    logic         av_p, av_np;
    logic [7:0]   side_p, side_np;

    int n_checks;
    int n_fail;

    logic [127:0] va [NV];
    logic [63:0]  vz [NV];
    logic         vv [NV];
    int           nv;

    always #5 clk = ~clk;

    mod_reduct_solinas3 #(.MOD_W(64), .MOD(MOD), .IN_PIPE(1), .SIDE_W(8), .RST_SIDE(2'b00)) dut (
        .clk(clk), .a_rst(a_rst), .a(a), .in_avail(in_avail), .in_side(in_side),
        .z(z_p), .out_avail(av_p), .out_side(side_p));

    mod_reduct_solinas3 #(.MOD_W(64), .MOD(MOD), .IN_PIPE(0), .SIDE_W(8), .RST_SIDE(2'b10)) dut_np (
        .clk(clk), .a_rst(a_rst), .a(a), .in_avail(in_avail), .in_side(in_side),
        .z(z_np), .out_avail(av_np), .out_side(side_np));

    task automatic add_vec(input logic [127:0] av, input logic [63:0] zv, input logic vld);
        va[nv] = av;
        vz[nv] = zv;
        vv[nv] = vld;
        nv++;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; a = {128{1'b1}}; in_avail = 1'b1; in_side = 8'h3C;
        repeat (3) @(negedge clk);
        n_checks++; if (z_p !== 64'd0)     begin n_fail++; $display("FAIL reset_z_p: got %h, want 0", z_p); end
        n_checks++; if (av_p !== 1'b0)     begin n_fail++; $display("FAIL reset_avail_p: got %b, want 0", av_p); end
        n_checks++; if (side_p !== 8'h00)  begin n_fail++; $display("FAIL reset_side_p: got %h, want 00", side_p); end
        n_checks++; if (z_np !== 64'd0)    begin n_fail++; $display("FAIL reset_z_np: got %h, want 0", z_np); end
        n_checks++; if (av_np !== 1'b0)    begin n_fail++; $display("FAIL reset_avail_np: got %b, want 0", av_np); end
        n_checks++; if (side_np !== 8'hFF) begin n_fail++; $display("FAIL reset_side_np: got %h, want ff", side_np); end
        in_avail = 1'b0; a = '0; in_side = 8'h00;
        a_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        a = '0; in_avail = 1'b1; in_side = 8'hA5;
        for (int j = 1; j <= LAT_P + 2; j++) begin
            @(posedge clk); @(negedge clk);
            in_avail = 1'b0;
            n_checks++; if (av_p !== (j == LAT_P))   begin n_fail++; $display("FAIL latency_avail_p[%0d]: got %b, want %b", j, av_p, j == LAT_P); end
            n_checks++; if (av_np !== (j == LAT_NP)) begin n_fail++; $display("FAIL latency_avail_np[%0d]: got %b, want %b", j, av_np, j == LAT_NP); end
            if (j == LAT_P) begin
                n_checks++; if (z_p !== 64'd0)    begin n_fail++; $display("FAIL latency_z_p: got %h, want 0", z_p); end
                n_checks++; if (side_p !== 8'hA5) begin n_fail++; $display("FAIL latency_side_p: got %h, want a5", side_p); end
            end
            if (j == LAT_NP) begin
                n_checks++; if (z_np !== 64'd0)    begin n_fail++; $display("FAIL latency_z_np: got %h, want 0", z_np); end
                n_checks++; if (side_np !== 8'hA5) begin n_fail++; $display("FAIL latency_side_np: got %h, want a5", side_np); end
            end
        end
    endtask

    // First seven entries carry the avail pattern 1,1,0,1,0,0,1; side is the entry index.
    task automatic test_directed();
        logic [127:0] m;
        int jp;
        int jn;
        m  = {64'd0, MOD};
        nv = 0;
        add_vec(128'd0, 64'd0, 1'b1);
        add_vec(m, 64'd0, 1'b1);
        add_vec(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 64'd0, 1'b0);
        add_vec(m - 128'd1, MOD - 64'd1, 1'b1);
        add_vec(128'h1234, 64'd0, 1'b0);
        add_vec(m + 128'd1, 64'd0, 1'b0);
        add_vec(128'd1 << 64, 64'h0000_0400_001F_FFFF, 1'b1);
        add_vec({128{1'b1}}, 64'h4000_01FF_FFCF_FFFF, 1'b1);
        add_vec((m - 128'd1) * (m - 128'd1), 64'd1, 1'b1);
        add_vec(m * 128'd2, 64'd0, 1'b1);
        add_vec(m * 128'd3, 64'd0, 1'b1);
        add_vec(m * 128'd4, 64'd0, 1'b1);
        add_vec(m + 128'd5, 64'd5, 1'b1);
        add_vec((128'd1 << 64) - 128'd1, 64'h0000_0400_001F_FFFE, 1'b1);
        add_vec(m * 128'd5 + 128'd7, 64'd7, 1'b1);
        add_vec(m * m, 64'd0, 1'b1);
        for (int c = 0; c < nv + LAT_P - 1; c++) begin
            if (c < nv) begin a = va[c]; in_avail = vv[c]; in_side = 8'(c); end
            else begin a = '0; in_avail = 1'b0; in_side = 8'h00; end
            @(posedge clk); @(negedge clk);
            jp = c - LAT_P + 1;
            jn = c - LAT_NP + 1;
            if (jp >= 0) begin
                n_checks++; if (av_p !== vv[jp]) begin n_fail++; $display("FAIL directed_avail_p[%0d]: got %b, want %b", jp, av_p, vv[jp]); end
                if (vv[jp]) begin
                    n_checks++; if (z_p !== vz[jp])       begin n_fail++; $display("FAIL directed_z_p[%0d]: got %h, want %h", jp, z_p, vz[jp]); end
                    n_checks++; if (side_p !== 8'(jp))    begin n_fail++; $display("FAIL directed_side_p[%0d]: got %h, want %h", jp, side_p, 8'(jp)); end
                end
            end
            if (jn >= 0 && jn < nv) begin
                n_checks++; if (av_np !== vv[jn]) begin n_fail++; $display("FAIL directed_avail_np[%0d]: got %b, want %b", jn, av_np, vv[jn]); end
                if (vv[jn]) begin
                    n_checks++; if (z_np !== vz[jn])      begin n_fail++; $display("FAIL directed_z_np[%0d]: got %h, want %h", jn, z_np, vz[jn]); end
                    n_checks++; if (side_np !== 8'(jn))   begin n_fail++; $display("FAIL directed_side_np[%0d]: got %h, want %h", jn, side_np, 8'(jn)); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] m;
        int jp;
        int jn;
        m  = {64'd0, MOD};
        nv = 0;
        for (int i = 0; i < NV; i++) begin
            va[i] = {$urandom, $urandom, $urandom, $urandom};
            vz[i] = 64'(va[i] % m);
            vv[i] = 1'b1;
        end
        nv = NV;
        for (int c = 0; c < nv + LAT_P - 1; c++) begin
            if (c < nv) begin a = va[c]; in_avail = 1'b1; in_side = 8'(c); end
            else begin a = '0; in_avail = 1'b0; end
            @(posedge clk); @(negedge clk);
            jp = c - LAT_P + 1;
            jn = c - LAT_NP + 1;
            if (jp >= 0) begin
                n_checks++; if (av_p !== 1'b1 || z_p !== vz[jp]) begin n_fail++; $display("FAIL random_p[%0d]: a=%h got z=%h avail=%b, want z=%h avail=1", jp, va[jp], z_p, av_p, vz[jp]); end
            end
            if (jn >= 0 && jn < nv) begin
                n_checks++; if (av_np !== 1'b1 || z_np !== vz[jn]) begin n_fail++; $display("FAIL random_np[%0d]: a=%h got z=%h avail=%b, want z=%h avail=1", jn, va[jn], z_np, av_np, vz[jn]); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        a = 128'd5; in_avail = 1'b0;
        repeat (LAT_P + 1) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            a = {64'd0, MOD} + 128'(i + 1); in_avail = 1'b1; in_side = 8'(8'hE0 + i);
            @(negedge clk);
        end
        in_avail = 1'b0;
        #2 a_rst = 1'b1;
        #1;
        n_checks++; if (av_p !== 1'b0)     begin n_fail++; $display("FAIL midrst_avail_p: got %b, want 0", av_p); end
        n_checks++; if (z_p !== 64'd0)     begin n_fail++; $display("FAIL midrst_z_p: got %h, want 0", z_p); end
        n_checks++; if (side_p !== 8'h00)  begin n_fail++; $display("FAIL midrst_side_p: got %h, want 00", side_p); end
        n_checks++; if (av_np !== 1'b0)    begin n_fail++; $display("FAIL midrst_avail_np: got %b, want 0", av_np); end
        n_checks++; if (z_np !== 64'd0)    begin n_fail++; $display("FAIL midrst_z_np: got %h, want 0", z_np); end
        n_checks++; if (side_np !== 8'hFF) begin n_fail++; $display("FAIL midrst_side_np: got %h, want ff", side_np); end
        @(negedge clk); @(negedge clk);
        a_rst = 1'b0;
        a = {64'd0, MOD} + 128'd9; in_avail = 1'b1; in_side = 8'h55;
        for (int j = 1; j <= LAT_P + 3; j++) begin
            @(posedge clk); @(negedge clk);
            in_avail = 1'b0;
            n_checks++; if (av_p !== (j == LAT_P))   begin n_fail++; $display("FAIL postrst_avail_p[%0d]: got %b, want %b", j, av_p, j == LAT_P); end
            n_checks++; if (av_np !== (j == LAT_NP)) begin n_fail++; $display("FAIL postrst_avail_np[%0d]: got %b, want %b", j, av_np, j == LAT_NP); end
            if (j == LAT_P) begin
                n_checks++; if (z_p !== 64'd9 || side_p !== 8'h55)   begin n_fail++; $display("FAIL postrst_data_p: got z=%h side=%h, want z=9 side=55", z_p, side_p); end
            end
            if (j == LAT_NP) begin
                n_checks++; if (z_np !== 64'd9 || side_np !== 8'h55) begin n_fail++; $display("FAIL postrst_data_np: got z=%h side=%h, want z=9 side=55", z_np, side_np); end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nv       = 0;
        a_rst    = 1'b1;
        a        = '0;
        in_avail = 1'b0;
        in_side  = 8'h00;
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
